// File: rtl/ud_counter_chain.sv
// Cascaded modulo-RADIX up/down counter with ripple carry/borrow, clamped load,
// terminal-count flag and wrap pulse. Define UD_CHAIN_SAT_EN for saturating mode.
module ud_counter_chain #(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10,
    localparam int DW    = (RADIX > 2) ? $clog2(RADIX) : 1
) (
    input  logic                 inter_clk,
    input  logic                 clr,
    input  logic                 ld,
    input  logic [DIGITS*DW-1:0] ld_val,
    input  logic                 cnt,
    input  logic                 up,
    output logic [DIGITS*DW-1:0] c,
    output logic                 tc,
    output logic                 wrap
);

    localparam logic [DW-1:0] MAX_D = DW'(RADIX - 1);

    logic [DIGITS-1:0][DW-1:0] c_q;
    logic [DIGITS-1:0][DW-1:0] c_next;
    logic [DIGITS-1:0][DW-1:0] ld_d;
    logic [DIGITS-1:0][DW-1:0] ld_clamped;
    logic                      lo_max;
    logic                      lo_zero;
    logic                      all_max;
    logic                      all_zero;
    logic                      wrap_q;

    function automatic logic [DW-1:0] digit_inc(input logic [DW-1:0] d);
        return (d == MAX_D) ? '0 : d + 1'b1;
    endfunction

    function automatic logic [DW-1:0] digit_dec(input logic [DW-1:0] d);
        return (d == '0) ? MAX_D : d - 1'b1;
    endfunction

    assign ld_d = ld_val;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        c_next     = c_q;
        ld_clamped = ld_d;
        lo_max     = 1'b1;
        lo_zero    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            // A digit steps only when every lower digit sits at its rollover value.
            if (up && lo_max) begin
                c_next[i] = digit_inc(c_q[i]);
            end else if (!up && lo_zero) begin
                c_next[i] = digit_dec(c_q[i]);
            end
            if (ld_d[i] > MAX_D) begin
                ld_clamped[i] = MAX_D;
            end
            lo_max  = lo_max && (c_q[i] == MAX_D);
            lo_zero = lo_zero && (c_q[i] == '0);
        end
        all_max  = lo_max;
        all_zero = lo_zero;
    end

    assign tc   = up ? all_max : all_zero;
    assign c    = c_q;
    assign wrap = wrap_q;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge inter_clk) begin
        if (clr) begin
            c_q    <= '0;
            wrap_q <= 1'b0;
        end else if (ld) begin
            c_q    <= ld_clamped;
            wrap_q <= 1'b0;
        end else if (cnt) begin
`ifdef UD_CHAIN_SAT_EN
            if (!tc) begin
                c_q <= c_next;
            end
            wrap_q <= 1'b0;
`else
            c_q    <= c_next;
            wrap_q <= tc;
`endif
        end else begin
            wrap_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ud_counter_chain.sv
// Scoreboard bench for ud_counter_chain: a 4x10 and a 2x6 instance driven by directed
// and random stimulus, checked against an integer mixed-radix reference model.
module tb_ud_counter_chain;

    logic        clk = 1'b0;
    logic        clr0 = 1'b0, ld0 = 1'b0, cnt0 = 1'b0, up0 = 1'b1;
    logic [15:0] ldv0 = '0;
    logic [15:0] c0;
    logic        tc0, wrap0;
    logic        clr1 = 1'b0, ld1 = 1'b0, cnt1 = 1'b0, up1 = 1'b1;
    logic [5:0]  ldv1 = '0;
    logic [5:0]  c1;
    logic        tc1, wrap1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] c;
        logic        w;
        logic        tc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int unsigned val_m[2] = '{0, 0};
    int          nd[2]    = '{4, 2};
    int          rdx[2]   = '{10, 6};
    int          dwd[2]   = '{4, 3};

    always #5 clk = ~clk;

    ud_counter_chain dut0 (
        .inter_clk(clk), .clr(clr0), .ld(ld0), .ld_val(ldv0),
        .cnt(cnt0), .up(up0), .c(c0), .tc(tc0), .wrap(wrap0)
    );

    ud_counter_chain #(.DIGITS(2), .RADIX(6)) dut1 (
        .inter_clk(clk), .clr(clr1), .ld(ld1), .ld_val(ldv1),
        .cnt(cnt1), .up(up1), .c(c1), .tc(tc1), .wrap(wrap1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned modulus(input int s);
        int unsigned m = 1;
        for (int i = 0; i < nd[s]; i++) m = m * rdx[s];
        return m;
    endfunction

    function automatic logic [31:0] to_bus(input int s, input int unsigned v);
        logic [31:0] b = '0;
        int unsigned x = v;
        for (int i = 0; i < nd[s]; i++) begin
            b = b | ((x % rdx[s]) << (i * dwd[s]));
            x = x / rdx[s];
        end
        return b;
    endfunction

    // Decode a load bus into an integer, clamping any out-of-range digit to RADIX-1.
    function automatic int unsigned from_load(input int s, input logic [31:0] bus);
        int unsigned v = 0;
        int unsigned p = 1;
        int unsigned d;
        for (int i = 0; i < nd[s]; i++) begin
            d = (bus >> (i * dwd[s])) & ((32'd1 << dwd[s]) - 1);
            if (d >= rdx[s]) d = rdx[s] - 1;
            v = v + d * p;
            p = p * rdx[s];
        end
        return v;
    endfunction

    function automatic logic model_tc(input int s, input logic u);
        return u ? (val_m[s] == modulus(s) - 1) : (val_m[s] == 0);
    endfunction

    // One clock of stimulus for instance s; the expected post-edge response goes to the scoreboard.
    task automatic step(input int s, input logic clr_i, input logic ld_i, input logic [31:0] ldv,
                        input logic cnt_i, input logic up_i);
        int unsigned m;
        logic        tcn;
        logic        w;
        exp_t        e;
        @(negedge clk);
        if (s == 0) begin
            clr0 = clr_i; ld0 = ld_i; ldv0 = ldv[15:0]; cnt0 = cnt_i; up0 = up_i;
        end else begin
            clr1 = clr_i; ld1 = ld_i; ldv1 = ldv[5:0]; cnt1 = cnt_i; up1 = up_i;
        end
        m   = modulus(s);
        tcn = model_tc(s, up_i);
        #1;
        check($sformatf("tc_comb%0d", s), (s == 0) ? 32'(tc0) : 32'(tc1), 32'(tcn));
        w = 1'b0;
        if (clr_i) begin
            val_m[s] = 0;
        end else if (ld_i) begin
            val_m[s] = from_load(s, ldv);
        end else if (cnt_i) begin
`ifdef UD_CHAIN_SAT_EN
            if (!tcn) val_m[s] = up_i ? (val_m[s] + 1) % m : (val_m[s] + m - 1) % m;
`else
            val_m[s] = up_i ? (val_m[s] + 1) % m : (val_m[s] + m - 1) % m;
            w = tcn;
`endif
        end
        e.c  = to_bus(s, val_m[s]);
        e.w  = w;
        e.tc = model_tc(s, up_i);
        if (s == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1;
        if (s == 0) begin
            clr0 = 1'b0; ld0 = 1'b0; cnt0 = 1'b0;
        end else begin
            clr1 = 1'b0; ld1 = 1'b0; cnt1 = 1'b0;
        end
    endtask

    task automatic lit0(input string name, input logic [15:0] exp_c, input logic exp_w);
        check({name, "_c"}, 32'(c0), 32'(exp_c));
        check({name, "_wrap"}, 32'(wrap0), 32'(exp_w));
    endtask

    always begin : mon0
        exp_t e;
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("sb0_c", 32'(c0), e.c);
            check("sb0_wrap", 32'(wrap0), 32'(e.w));
            check("sb0_tc", 32'(tc0), 32'(e.tc));
        end
    end

    always begin : mon1
        exp_t e;
        @(posedge clk);
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("sb1_c", 32'(c1), e.c);
            check("sb1_wrap", 32'(wrap1), 32'(e.w));
            check("sb1_tc", 32'(tc1), 32'(e.tc));
        end
    end

    initial begin
        logic [31:0] lv;
        logic        u;
        logic [15:0] picks[5];
        // Reset wins over load and count; tc=1 at zero when counting down.
        step(0, 1, 1, 32'h1234, 1, 0);
        lit0("t1", 16'h0000, 1'b0);
        check("t1_tc", 32'(tc0), 32'd1);
        // Carry ripple through two digits.
        step(0, 0, 1, 32'h0199, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        lit0("t2a", 16'h0200, 1'b0);
        step(0, 0, 0, 0, 1, 1);
        lit0("t2b", 16'h0201, 1'b0);
        // Borrow from zero.
        step(0, 0, 1, 32'h0000, 0, 0);
        step(0, 0, 0, 0, 1, 0);
`ifdef UD_CHAIN_SAT_EN
        lit0("t3a", 16'h0000, 1'b0);
        step(0, 0, 0, 0, 1, 0);
        lit0("t3b", 16'h0000, 1'b0);
`else
        lit0("t3a", 16'h9999, 1'b1);
        step(0, 0, 0, 0, 1, 0);
        lit0("t3b", 16'h9998, 1'b0);
`endif
        // Load clamp, then direction toggles with cnt=0.
        step(0, 0, 1, 32'hFA3C, 0, 1);
        lit0("t4a", 16'h9939, 1'b0);
        step(0, 0, 1, 32'h9999, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("t4_tc_up", 32'(tc0), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        check("t4_tc_dn", 32'(tc0), 32'd0);
        lit0("t4b", 16'h9999, 1'b0);
        // Reach terminal going up, then reverse without a wrap pulse.
        step(0, 0, 1, 32'h9998, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        lit0("t5a", 16'h9999, 1'b0);
        check("t5_tc", 32'(tc0), 32'd1);
        step(0, 0, 0, 0, 1, 0);
        lit0("t5b", 16'h9998, 1'b0);
        // Up wrap, and reset on a would-wrap edge.
        step(0, 0, 1, 32'h9999, 0, 1);
        step(0, 0, 0, 0, 1, 1);
`ifdef UD_CHAIN_SAT_EN
        lit0("t5c", 16'h9999, 1'b0);
`else
        lit0("t5c", 16'h0000, 1'b1);
`endif
        step(0, 0, 1, 32'h9999, 0, 1);
        step(0, 1, 0, 0, 1, 1);
        lit0("t5d", 16'h0000, 1'b0);
        step(0, 0, 0, 0, 1, 1);
        lit0("t5e", 16'h0001, 1'b0);
        // Small instance: 55 + up step, then clamped load of 77.
        step(1, 0, 1, {26'd0, 3'd5, 3'd5}, 0, 1);
        step(1, 0, 0, 0, 1, 1);
`ifdef UD_CHAIN_SAT_EN
        check("t6a_c", 32'(c1), {26'd0, 3'd5, 3'd5});
        check("t6a_wrap", 32'(wrap1), 32'd0);
`else
        check("t6a_c", 32'(c1), 32'd0);
        check("t6a_wrap", 32'(wrap1), 32'd1);
`endif
        step(1, 0, 1, {26'd0, 3'd7, 3'd7}, 0, 1);
        check("t6b_c", 32'(c1), {26'd0, 3'd5, 3'd5});

        // Random phase, load values biased toward the terminal states.
        picks = '{16'h9999, 16'h0000, 16'h9998, 16'h0001, 16'h0990};
        u = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) u = ~u;
            lv = ($urandom_range(1) == 0) ? 32'(picks[$urandom_range(4)]) : 32'($urandom_range(16'hFFFF));
            step(0, ($urandom_range(31) == 0), ($urandom_range(7) == 0), lv,
                 ($urandom_range(3) != 0), u);
        end
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(3) == 0) u = ~u;
            lv = 32'($urandom_range(6'h3F));
            step(1, ($urandom_range(31) == 0), ($urandom_range(7) == 0), lv,
                 ($urandom_range(3) != 0), u);
        end

        repeat (3) @(posedge clk);
        #2;
        check("drain0", 32'(q0.size()), 32'd0);
        check("drain1", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
